gpr_serial_port: RTL

//  Host-side access port for the bit-serial general-purpose register file.
//  - Converts one parallel read or write request into WIDTH serial shift cycles on the register file.
//  - Drives the file's shift, write, data-in and address controls, and samples its serial data output.
//  - A write returns the old register contents (swap). A read rotates the register back to its original value.

---
 rtl/gpr_serial_port_if.sv | 40 ++++
 rtl/gpr_serial_port.sv | 118 +++++++++++
 2 files changed

// File: rtl/gpr_serial_port_if.sv
// Bus bundle between host, serial access port and bit-serial register file.
// o_rparity exists only when GPR_PORT_PARITY_EN is defined.
interface gpr_serial_port_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = 2
);
  // Host side
  logic              i_req;
  logic              i_we;
  logic [ADDR_W-1:0] i_addr;
  logic [WIDTH-1:0]  i_wdata;
  logic              o_busy;
  logic              o_done;
  logic [WIDTH-1:0]  o_rdata;
`ifdef GPR_PORT_PARITY_EN
  logic              o_rparity;
`endif
  // Register-file side
  logic              o_con_shift;
  logic              o_con_write;
  logic              o_data_in;
  logic [ADDR_W-1:0] o_rd_addr;
  logic              i_data_out;

  modport slave (
`ifdef GPR_PORT_PARITY_EN
    output o_rparity,
`endif
    input  i_req, i_we, i_addr, i_wdata, i_data_out,
    output o_busy, o_done, o_rdata, o_con_shift, o_con_write, o_data_in, o_rd_addr
  );

  modport master (
`ifdef GPR_PORT_PARITY_EN
    input  o_rparity,
`endif
    output i_req, i_we, i_addr, i_wdata, i_data_out,
    input  o_busy, o_done, o_rdata, o_con_shift, o_con_write, o_data_in, o_rd_addr
  );
endinterface

// File: rtl/gpr_serial_port.sv
// Serial access port: one parallel read/write becomes WIDTH shift cycles on the register file.
// Define GPR_PORT_PARITY_EN to add o_rparity (XOR of the bits read out). Requires WIDTH >= 2.
module gpr_serial_port #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  gpr_serial_port_if.slave bus_io
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  wsh_q, wsh_d;
  logic [WIDTH-1:0]  rsh_q, rsh_d;
  logic [WIDTH-1:0]  rdata_q, rdata_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
`ifdef GPR_PORT_PARITY_EN
  logic              par_q, par_d;
  logic              rparity_q, rparity_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wsh_d   = wsh_q;
    rsh_d   = rsh_q;
    rdata_d = rdata_q;
    we_d    = we_q;
    addr_d  = addr_q;
`ifdef GPR_PORT_PARITY_EN
    par_d     = par_q;
    rparity_d = rparity_q;
`endif
    case (state_q)
      StIdle: begin
        if (bus_io.i_req) begin
          state_d = StShift;
          cnt_d   = '0;
          wsh_d   = bus_io.i_wdata;
          we_d    = bus_io.i_we;
          addr_d  = bus_io.i_addr;
          rsh_d   = '0;
`ifdef GPR_PORT_PARITY_EN
          par_d   = 1'b0;
`endif
        end
      end
      StShift: begin
        // The file's bit 0 arrives LSB first, so it fills from the top down.
        rsh_d = {bus_io.i_data_out, rsh_q[WIDTH-1:1]};
        wsh_d = wsh_q >> 1;
`ifdef GPR_PORT_PARITY_EN
        par_d = par_q ^ bus_io.i_data_out;
`endif
        if (cnt_q == CntLast) begin
          rdata_d = rsh_d;
`ifdef GPR_PORT_PARITY_EN
          rparity_d = par_d;
`endif
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      wsh_q   <= '0;
      rsh_q   <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
`ifdef GPR_PORT_PARITY_EN
      par_q     <= 1'b0;
      rparity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wsh_q   <= wsh_d;
      rsh_q   <= rsh_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
`ifdef GPR_PORT_PARITY_EN
      par_q     <= par_d;
      rparity_q <= rparity_d;
`endif
    end
  end

  always_comb begin
    bus_io.o_busy      = (state_q != StIdle);
    bus_io.o_done      = (state_q == StDone);
    bus_io.o_rdata     = rdata_q;
    bus_io.o_con_shift = (state_q == StShift);
    bus_io.o_con_write = (state_q == StShift) & we_q;
    bus_io.o_data_in   = (state_q == StShift) & wsh_q[0];
    bus_io.o_rd_addr   = addr_q;
`ifdef GPR_PORT_PARITY_EN
    bus_io.o_rparity   = rparity_q;
`endif
  end

endmodule
